// File: rtl/dram_ctrl_pkg.sv
// ============================================================================
// dram_ctrl_pkg : shared types, parameter checks and counter sizing for the
//                 DRAM strobe controller.           Rev 1.0
// ============================================================================
`default_nettype none

package dram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_COL  = 3'd2,
        ST_CAS  = 3'd3,
        ST_PRE  = 3'd4,
        ST_REF  = 3'd5
    } state_t;

    localparam int c_MAX_BANKS = 8;

    function automatic bit params_ok(input int banks, input int r2m,
                                     input int m2c, input int pre);
        return (banks >= 1) && (banks <= c_MAX_BANKS) &&
               (r2m >= 1) && (m2c >= 1) && (pre >= 1);
    endfunction

    function automatic int cnt_width(input int r2m, input int m2c, input int pre);
        int m;
        m = r2m;
        if (m2c > m) m = m2c;
        if (pre > m) m = pre;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dram_bank_sel.sv
// ============================================================================
// dram_bank_sel : lowest-index active-low slot select -> latched one-hot bank.
//                                                    Rev 1.0
// ============================================================================
`default_nettype none

module dram_bank_sel #(
    parameter int BANKS = 2
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [BANKS-1:0] i_nsltsl,
    input  logic             i_load,
    output logic             o_any_sel,
    output logic [BANKS-1:0] o_bank
);

    logic [BANKS-1:0] w_active;
    logic [BANKS-1:0] w_onehot;
    logic [BANKS-1:0] r_bank;

    // x & -x isolates the lowest set bit, giving lowest-index priority.
    assign w_active  = ~i_nsltsl;
    assign w_onehot  = w_active & (~w_active + BANKS'(1));
    assign o_any_sel = |w_active;
    assign o_bank    = r_bank;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_bank <= '0;
        end else if (i_load) begin
            r_bank <= w_onehot;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dram_strobe_ctrl.sv
// ============================================================================
// dram_strobe_ctrl : /RAS, row/column MUX and per-bank /CAS generator for the
//                    Z80 DRAM subsystem. Macro CBR_REFRESH_EN selects
//                    CAS-before-RAS refresh instead of RAS-only refresh.
//                                                    Rev 1.0
// ============================================================================
`default_nettype none

module dram_strobe_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int BANKS      = 2,
    parameter int RAS_TO_MUX = 1,
    parameter int MUX_TO_CAS = 1,
    parameter int PRECHARGE  = 2
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             nmreq,
    input  logic             nrfsh,
    input  logic             nwr,
    input  logic [BANKS-1:0] nsltsl,
    output logic             nras,
    output logic             mux,
    output logic [BANKS-1:0] ncas,
    output logic             nwe,
    output logic             busy
);

    localparam int c_CW = cnt_width(RAS_TO_MUX, MUX_TO_CAS, PRECHARGE);
    localparam logic [c_CW-1:0] c_LD_R2M = c_CW'(RAS_TO_MUX - 1);
    localparam logic [c_CW-1:0] c_LD_M2C = c_CW'(MUX_TO_CAS - 1);
    localparam logic [c_CW-1:0] c_LD_PRE = c_CW'(PRECHARGE - 1);

    generate
        if (!params_ok(BANKS, RAS_TO_MUX, MUX_TO_CAS, PRECHARGE)) begin : g_bad_params
            $error("dram_strobe_ctrl: parameter out of range");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_idle_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [c_CW-1:0]   w_idle_cnt;
    logic [BANKS-1:0]  w_bank;
    logic              w_any_sel;
    logic              w_req_row;
    logic              w_req_ref;
    logic              w_bank_load;
    logic              w_ref_ras;
    logic              w_ref_cas;
    logic              w_ras_on;
    logic [BANKS-1:0]  w_ncas_nxt;

    logic              r_nras;
    logic              r_mux;
    logic [BANKS-1:0]  r_ncas;
    logic              r_nwe;
    logic              r_busy;

    dram_bank_sel #(
        .BANKS (BANKS)
    ) u_bank_sel (
        .clk       (clk),
        .nreset    (nreset),
        .i_nsltsl  (nsltsl),
        .i_load    (w_bank_load),
        .o_any_sel (w_any_sel),
        .o_bank    (w_bank)
    );

    assign w_req_row = !nmreq && nrfsh && w_any_sel;
    assign w_req_ref = !nmreq && !nrfsh;

    assign w_idle_state = w_req_ref ? ST_REF : (w_req_row ? ST_ROW : ST_IDLE);
    assign w_idle_cnt   = (w_req_row && !w_req_ref) ? c_LD_R2M : '0;

    // The last precharge clock doubles as the idle decision point so that a
    // waiting request gets /RAS back exactly PRECHARGE clocks after it rose.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bank_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = w_idle_state;
                w_cnt_nxt   = w_idle_cnt;
                w_bank_load = (w_idle_state == ST_ROW);
            end
            ST_ROW: begin
                if (nmreq) begin
                    w_state_nxt = ST_PRE;
                    w_cnt_nxt   = c_LD_PRE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_COL;
                    w_cnt_nxt   = c_LD_M2C;
                end else begin
                    w_cnt_nxt   = r_cnt - c_CW'(1);
                end
            end
            ST_COL: begin
                if (nmreq) begin
                    w_state_nxt = ST_PRE;
                    w_cnt_nxt   = c_LD_PRE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_CAS;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - c_CW'(1);
                end
            end
            ST_CAS, ST_REF: begin
                if (nmreq) begin
                    w_state_nxt = ST_PRE;
                    w_cnt_nxt   = c_LD_PRE;
                end
            end
            ST_PRE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt   = r_cnt - c_CW'(1);
                end else begin
                    w_state_nxt = w_idle_state;
                    w_cnt_nxt   = w_idle_cnt;
                    w_bank_load = (w_idle_state == ST_ROW);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef CBR_REFRESH_EN
    // CBR: /CAS leads on the first refresh clock, /RAS joins from the second.
    assign w_ref_ras = (r_state == ST_REF);
    assign w_ref_cas = 1'b1;
`else
    assign w_ref_ras = 1'b1;
    assign w_ref_cas = 1'b0;
`endif

    assign w_ras_on = (w_state_nxt == ST_ROW) || (w_state_nxt == ST_COL) ||
                      (w_state_nxt == ST_CAS) ||
                      ((w_state_nxt == ST_REF) && w_ref_ras);

    assign w_ncas_nxt = (w_state_nxt == ST_CAS) ? ~w_bank :
                        ((w_state_nxt == ST_REF) && w_ref_cas) ? '0 : '1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_nras  <= 1'b1;
            r_mux   <= 1'b0;
            r_ncas  <= '1;
            r_nwe   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nras  <= !w_ras_on;
            r_mux   <= (w_state_nxt == ST_COL) || (w_state_nxt == ST_CAS);
            r_ncas  <= w_ncas_nxt;
            r_nwe   <= (w_state_nxt == ST_CAS) ? nwr : 1'b1;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign nras = r_nras;
    assign mux  = r_mux;
    assign ncas = r_ncas;
    assign nwe  = r_nwe;
    assign busy = r_busy;

endmodule

`default_nettype wire
